// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types, segment lookup table and pattern-to-nibble decode
// for the 7-segment encoder/reader pair. Segment order is g..a (bit 6..0),
// active-low.
package seg7_pkg;

   typedef logic [6:0] seg_t;
   typedef logic [3:0] nib_t;

   // Active-low patterns for nibbles 0..F, bit 6 = g ... bit 0 = a.
   localparam seg_t SEG_LUT [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   // All segments off.
   localparam seg_t SEG_BLANK = 7'b1111111;

   // Reverse lookup: returns the nibble whose pattern matches seg and sets ok.
   // An unknown pattern returns 0 with ok cleared.
   function automatic nib_t seg2nib(input seg_t seg, output logic ok);
      nib_t n;
      n  = 4'h0;
      ok = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (seg == SEG_LUT[k]) begin
            n  = nib_t'(k);
            ok = 1'b1;
         end else begin
            ok = ok;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/seg7_stab.sv
// seg7_stab: samples a W-bit vector every clock and pulses cap on the edge
// where the vector has been seen unchanged for STABLE_CYC consecutive edges
// after its first appearance. q is the registered sample.
module seg7_stab #(
   parameter int W          = 11,
   parameter int STABLE_CYC = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic         cap,
   output logic [W-1:0] q
);

   localparam int CW = $clog2(STABLE_CYC + 1);
   localparam logic [CW-1:0] CNT_SAT  = CW'(STABLE_CYC);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYC - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [W-1:0]  samp_r;
   logic [CW-1:0] cnt_r;
   logic          same_s;

   assign same_s = (d == samp_r);
   // Fires only on the transition into saturation, so a held pattern captures once.
   assign cap    = same_s && (cnt_r == CNT_LAST);
   assign q      = samp_r;

   // Sample register and saturating run counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samp_r <= {W{1'b1}};
         cnt_r  <= {CW{1'b0}};
      end else begin
         samp_r <= d;
         if (!same_s) begin
            cnt_r <= {CW{1'b0}};
         end else if (cnt_r != CNT_SAT) begin
            cnt_r <= cnt_r + CNT_ONE;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

endmodule

// File: rtl/seg7_reader.sv
// seg7_reader: recovers hex nibbles from a scanned active-low 7-segment bus.
// Waits for {an,dis} to be stable, decodes the pattern and stores it per digit.
// Optional macro SEG7_RD_BLANK_EN: an all-off pattern is treated as a blank
// digit (invalidates the digit, no error) instead of an undecodable pattern.
module seg7_reader
   import seg7_pkg::*;
#(
   parameter int N_DIG      = 4,
   parameter int STABLE_CYC = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [6:0]                    dis,
   input  logic [N_DIG-1:0]              an,
   input  logic                          clr,
   output logic [4*N_DIG-1:0]            hex,
   output logic [N_DIG-1:0]              dig_vld,
   output logic                          upd,
   output logic [((N_DIG>1)?$clog2(N_DIG):1)-1:0] upd_idx,
   output logic                          err
);

   localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
   localparam int W  = N_DIG + 7;
   localparam logic [N_DIG-1:0] ONE_V = N_DIG'(1);

   logic [W-1:0]       in_s;
   logic [W-1:0]       samp_s;
   logic               cap_s;
   logic [N_DIG-1:0]   sel_s;
   seg_t               dis_s;
   nib_t               nib_s;
   logic               ok_s;
   logic               one_s;
   logic               blank_s;
   logic [IW-1:0]      idx_s;

   logic [4*N_DIG-1:0] hex_r, hex_n;
   logic [N_DIG-1:0]   vld_r, vld_n;
   logic               upd_r, upd_n;
   logic [IW-1:0]      idx_r, idx_n;
   logic               err_r, err_n;

   assign in_s = {an, dis};

   seg7_stab #(
      .W          (W),
      .STABLE_CYC (STABLE_CYC)
   ) u_stab (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (in_s),
      .cap   (cap_s),
      .q     (samp_s)
   );

   // Decode works from the registered sample, which equals the inputs when cap fires.
   assign sel_s = ~samp_s[W-1:7];
   assign dis_s = samp_s[6:0];
   assign one_s = (sel_s != {N_DIG{1'b0}}) && ((sel_s & (sel_s - ONE_V)) == {N_DIG{1'b0}});

`ifdef SEG7_RD_BLANK_EN
   assign blank_s = (dis_s == SEG_BLANK);
`else
   assign blank_s = 1'b0;
`endif

   // Pattern-to-nibble lookup.
   always_comb begin
      ok_s  = 1'b0;
      nib_s = seg2nib(dis_s, ok_s);
   end

   // Position of the low select bit (meaningful only when one_s is set).
   always_comb begin
      idx_s = {IW{1'b0}};
      for (int i = 0; i < N_DIG; i++) begin
         if (sel_s[i]) begin
            idx_s = IW'(i);
         end else begin
            idx_s = idx_s;
         end
      end
   end

   // Next-state: clear first, then a capture overrides its own digit and error bit.
   always_comb begin
      hex_n = clr ? {4*N_DIG{1'b0}} : hex_r;
      vld_n = clr ? {N_DIG{1'b0}}   : vld_r;
      err_n = clr ? 1'b0            : err_r;
      upd_n = 1'b0;
      idx_n = idx_r;
      if (cap_s && one_s) begin
         upd_n = 1'b1;
         idx_n = idx_s;
         for (int i = 0; i < N_DIG; i++) begin
            if (sel_s[i]) begin
               if (ok_s) begin
                  hex_n[4*i +: 4] = nib_s;
                  vld_n[i]        = 1'b1;
               end else begin
                  hex_n[4*i +: 4] = hex_r[4*i +: 4];
                  vld_n[i]        = 1'b0;
               end
            end else begin
               vld_n[i] = vld_n[i];
            end
         end
         if (!ok_s && !blank_s) begin
            err_n = 1'b1;
         end else begin
            err_n = err_n;
         end
      end else begin
         upd_n = 1'b0;
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hex_r <= {4*N_DIG{1'b0}};
         vld_r <= {N_DIG{1'b0}};
         upd_r <= 1'b0;
         idx_r <= {IW{1'b0}};
         err_r <= 1'b0;
      end else begin
         hex_r <= hex_n;
         vld_r <= vld_n;
         upd_r <= upd_n;
         idx_r <= idx_n;
         err_r <= err_n;
      end
   end

   assign hex     = hex_r;
   assign dig_vld = vld_r;
   assign upd     = upd_r;
   assign upd_idx = idx_r;
   assign err     = err_r;

endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: directed scenarios plus a randomized run, checked against a
// run-length / lookup-table reference model of the display reader.
module tb_seg7_reader;

   localparam int S = 4;

   logic        clk;
   logic        rst_n;
   logic [6:0]  dis;
   logic [3:0]  an;
   logic        clr;
   logic [15:0] hex;
   logic [3:0]  dig_vld;
   logic        upd;
   logic [1:0]  upd_idx;
   logic        err;

   int total;
   int bad;

   logic [6:0] pats [16];

   // reference model state
   logic [10:0] m_prev;
   int          m_run;
   logic [15:0] m_hex;
   logic [3:0]  m_vld;
   logic        m_err;
   logic        m_upd;
   logic [1:0]  m_idx;

   seg7_reader #(.N_DIG(4), .STABLE_CYC(S)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .dis     (dis),
      .an      (an),
      .clr     (clr),
      .hex     (hex),
      .dig_vld (dig_vld),
      .upd     (upd),
      .upd_idx (upd_idx),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // pattern table written from the display's g..a truth table
   function automatic logic [4:0] ref_dec(input logic [6:0] p);
      case (p)
         7'b1000000: return 5'h10;  7'b1111001: return 5'h11;
         7'b0100100: return 5'h12;  7'b0110000: return 5'h13;
         7'b0011001: return 5'h14;  7'b0010010: return 5'h15;
         7'b0000010: return 5'h16;  7'b1111000: return 5'h17;
         7'b0000000: return 5'h18;  7'b0010000: return 5'h19;
         7'b0001000: return 5'h1A;  7'b0000011: return 5'h1B;
         7'b1000110: return 5'h1C;  7'b0100001: return 5'h1D;
         7'b0000110: return 5'h1E;  7'b0001110: return 5'h1F;
         default:    return 5'h00;
      endcase
   endfunction

   function automatic bit ref_blank(input logic [6:0] p);
`ifdef SEG7_RD_BLANK_EN
      return (p == 7'b1111111);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      m_prev = 11'h7FF;
      m_run  = 1;
      m_hex  = 16'h0;
      m_vld  = 4'h0;
      m_err  = 1'b0;
      m_upd  = 1'b0;
      m_idx  = 2'd0;
   endtask

   // a value first present at edge e0 captures at e0+S, i.e. when its run reaches S+1
   task automatic model_edge();
      logic [10:0] cur;
      logic [15:0] old;
      logic [4:0]  r;
      int zc, p;
      if (!rst_n) return;
      cur = {an, dis};
      if (cur == m_prev) m_run++;
      else m_run = 1;
      m_prev = cur;
      old = m_hex;
      m_upd = 1'b0;
      if (clr) begin
         m_hex = 16'h0; m_vld = 4'h0; m_err = 1'b0;
      end
      if (m_run == S + 1) begin
         zc = 0; p = 0;
         for (int i = 0; i < 4; i++) if (!an[i]) begin zc++; p = i; end
         if (zc == 1) begin
            m_upd = 1'b1;
            m_idx = p[1:0];
            r = ref_dec(dis);
            if (r[4]) begin
               m_hex[4*p +: 4] = r[3:0];
               m_vld[p] = 1'b1;
            end else begin
               m_hex[4*p +: 4] = old[4*p +: 4];
               m_vld[p] = 1'b0;
               if (!ref_blank(dis)) m_err = 1'b1;
            end
         end
      end
   endtask

   task automatic cycle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
      end
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      cycle(1);
      clr = 1'b0;
   endtask

   task automatic test_reset();
      int first, cnt;
      an = 4'b1110; dis = pats[5];
      cycle(2);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if ({hex, dig_vld, upd, upd_idx, err} !== 27'h0) begin
         bad++;
         $display("FAIL reset_outputs: got hex=%h vld=%b upd=%b idx=%0d err=%b want all zero",
                  hex, dig_vld, upd, upd_idx, err);
      end
      @(negedge clk);
      cycle(1);
      rst_n = 1'b1;
      first = 0; cnt = 0;
      for (int k = 1; k <= 10; k++) begin
         cycle(1);
         if (upd) begin cnt++; if (first == 0) first = k; end
      end
      total++;
      if (first !== S + 1 || cnt !== 1) begin
         bad++;
         $display("FAIL reset_release_upd: got first=%0d count=%0d want first=%0d count=1",
                  first, cnt, S + 1);
      end
      total++;
      if (hex[3:0] !== 4'h5 || dig_vld !== 4'b0001) begin
         bad++;
         $display("FAIL reset_release_cap: got hex=%h vld=%b want nib 5 vld 0001", hex, dig_vld);
      end
   endtask

   task automatic test_valid();
      int first, cnt;
      pulse_clr();
      an = 4'b1101; dis = 7'b0110000;
      first = 0; cnt = 0;
      for (int k = 1; k <= 10; k++) begin
         cycle(1);
         if (upd) begin
            cnt++;
            if (first == 0) first = k;
            total++;
            if (upd_idx !== 2'd1) begin
               bad++;
               $display("FAIL valid_idx: got %0d want 1", upd_idx);
            end
         end
      end
      total++;
      if (first !== S + 1 || cnt !== 1) begin
         bad++;
         $display("FAIL valid_upd: got first=%0d count=%0d want first=%0d count=1", first, cnt, S + 1);
      end
      total++;
      if (hex[7:4] !== 4'h3 || dig_vld !== 4'b0010) begin
         bad++;
         $display("FAIL valid_data: got hex=%h vld=%b want nib1=3 vld=0010", hex, dig_vld);
      end
   endtask

   task automatic test_glitch();
      int first;
      an = 4'b1101; dis = 7'b0000000;
      first = 0;
      for (int k = 1; k <= 12; k++) begin
         if (k == 4) dis = 7'b1111000;
         cycle(1);
         if (upd && first == 0) first = k;
      end
      total++;
      if (first !== 3 + S + 1) begin
         bad++;
         $display("FAIL glitch_timing: got first upd at %0d want %0d", first, 3 + S + 1);
      end
      total++;
      if (hex[7:4] !== 4'h7) begin
         bad++;
         $display("FAIL glitch_value: got nib1=%h want 7", hex[7:4]);
      end
   endtask

   task automatic test_error();
      an = 4'b0111; dis = 7'b1010101;
      cycle(6);
      total++;
      if (err !== 1'b1 || dig_vld[3] !== 1'b0 || upd_idx !== 2'd3) begin
         bad++;
         $display("FAIL error_set: got err=%b vld3=%b idx=%0d want 1 0 3", err, dig_vld[3], upd_idx);
      end
      an = 4'b1110; dis = 7'b1000000;
      cycle(S);
      clr = 1'b1;
      cycle(1);
      clr = 1'b0;
      total++;
      if (err !== 1'b0 || dig_vld !== 4'b0001 || upd !== 1'b1 || hex !== 16'h0000) begin
         bad++;
         $display("FAIL clr_vs_cap: got err=%b vld=%b upd=%b hex=%h want 0 0001 1 0000",
                  err, dig_vld, upd, hex);
      end
   endtask

   task automatic test_invalid_sel();
      int cnt;
      logic [3:0] sels [2];
      sels[0] = 4'b1100; sels[1] = 4'b1111;
      for (int s = 0; s < 2; s++) begin
         an = sels[s]; dis = pats[3];
         cnt = 0;
         for (int k = 0; k < 10; k++) begin
            cycle(1);
            if (upd) cnt++;
         end
         total++;
         if (cnt !== 0 || err !== 1'b0) begin
            bad++;
            $display("FAIL invalid_sel_%b: got upd count=%0d err=%b want 0 0", sels[s], cnt, err);
         end
      end
   endtask

   task automatic test_scan();
      pulse_clr();
      for (int i = 0; i < 4; i++) begin
         an = ~(4'b0001 << i);
         dis = pats[10 + i];
         cycle(6);
      end
      total++;
      if (hex !== 16'hDCBA || dig_vld !== 4'hF) begin
         bad++;
         $display("FAIL scan: got hex=%h vld=%h want DCBA F", hex, dig_vld);
      end
      an = 4'b1110; dis = 7'b1111111;
      cycle(6);
      total++;
`ifdef SEG7_RD_BLANK_EN
      if (err !== 1'b0 || dig_vld !== 4'hE || hex !== 16'hDCBA) begin
         bad++;
         $display("FAIL blank: got err=%b vld=%h hex=%h want 0 E DCBA", err, dig_vld, hex);
      end
`else
      if (err !== 1'b1 || dig_vld !== 4'hE || hex !== 16'hDCBA) begin
         bad++;
         $display("FAIL blank: got err=%b vld=%h hex=%h want 1 E DCBA", err, dig_vld, hex);
      end
`endif
   endtask

   task automatic test_random();
      int hold, errs;
      errs = 0;
      for (int seg = 0; seg < 120; seg++) begin
         if ($urandom_range(0, 99) < 85) an = ~(4'b0001 << $urandom_range(0, 3));
         else an = 4'($urandom);
         if ($urandom_range(0, 99) < 80) dis = pats[$urandom_range(0, 15)];
         else dis = 7'($urandom);
         hold = $urandom_range(1, 7);
         for (int k = 0; k < hold; k++) begin
            clr = ($urandom_range(0, 99) < 5);
            cycle(1);
            total++;
            if (hex !== m_hex || dig_vld !== m_vld || err !== m_err || upd !== m_upd || upd_idx !== m_idx) begin
               bad++;
               if (errs < 10)
                  $display("FAIL random: got hex=%h vld=%b err=%b upd=%b idx=%0d want hex=%h vld=%b err=%b upd=%b idx=%0d",
                           hex, dig_vld, err, upd, upd_idx, m_hex, m_vld, m_err, m_upd, m_idx);
               errs++;
            end
         end
      end
      clr = 1'b0;
   endtask

   initial begin
      total = 0; bad = 0;
      pats[0]  = 7'b1000000; pats[1]  = 7'b1111001; pats[2]  = 7'b0100100; pats[3]  = 7'b0110000;
      pats[4]  = 7'b0011001; pats[5]  = 7'b0010010; pats[6]  = 7'b0000010; pats[7]  = 7'b1111000;
      pats[8]  = 7'b0000000; pats[9]  = 7'b0010000; pats[10] = 7'b0001000; pats[11] = 7'b0000011;
      pats[12] = 7'b1000110; pats[13] = 7'b0100001; pats[14] = 7'b0000110; pats[15] = 7'b0001110;
      rst_n = 1'b0; an = 4'hF; dis = 7'h7F; clr = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_valid();
      test_glitch();
      test_error();
      test_invalid_sel();
      test_scan();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg7_reader.md
# seg7_reader

Recovers hex nibbles from a scanned, active-low 7-segment display bus. It samples the segment pattern and the active-low digit selects, waits until both are stable, decodes the pattern back to a 4-bit value, and stores it per digit. It sits on the monitor side of the display path: it reads the display outputs back for self-check, loopback and lab-bench readout. It is the inverse of the team's hex-to-segment encoder.

## Interface
- `N_DIG`, default 4: number of scanned digits; range 1..8.
- `STABLE_CYC`, default 4: consecutive identical samples required before a capture; must be ≥1.
- `clk` in, 1: system clock, rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `dis` in, 7: segment pattern, active-low. `dis[0]`=a … `dis[6]`=g.
- `an` in, `N_DIG`: digit select, active-low, one-hot-low when valid.
- `clr` in, 1: synchronous clear of `hex`, `dig_vld` and `err`.
- `hex` out, `4*N_DIG`: decoded nibbles; digit i is at `[4i+3:4i]`.
- `dig_vld` out, `N_DIG`: digit i holds a valid capture.
- `upd` out, 1: one-cycle pulse on every capture.
- `upd_idx` out, `$clog2(N_DIG)` (min 1): digit index of the current capture.
- `err` out, 1: sticky flag; set by an undecodable pattern on a valid digit.

## Operation
- **Reset:** `hex`=0, `dig_vld`=0, `upd`=0, `upd_idx`=0, `err`=0. Sample register `s_q`=all-ones ({`an`,`dis`}). `cnt`=0.
- **Stability counter:**
  - On each edge, compare {`an`,`dis`} with `s_q`.
  - If equal, `cnt` increments and saturates at `STABLE_CYC`; otherwise `cnt`=0.
  - `s_q` always loads the inputs.
- **Capture:**
  - A capture fires on the edge where `cnt` goes from `STABLE_CYC-1` to `STABLE_CYC`.
  - At most one capture per stable period; a saturated `cnt` fires nothing.
- **Select validity:** at capture, `an` must have exactly one bit low. All-high or multiple-low selects cause no capture, no `upd`, and no `err`.
- **Decode** (pattern→nibble), from `dis` in bit order g..a:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3
  - 0011001→4, 0010010→5, 0000010→6, 1111000→7
  - 0000000→8, 0010000→9, 0001000→A, 0000011→b
  - 1000110→C, 0100001→d, 0000110→E, 0001110→F
- **Valid capture:**
  - `hex[i]`=nibble, `dig_vld[i]`=1, `upd`=1, `upd_idx`=i.
- **Undecodable pattern:**
  - `dig_vld[i]`=0 and `hex[i]` is held.
  - `err`=1, `upd`=1, `upd_idx`=i.
- **Clear:** `clr` zeroes `hex`, `dig_vld` and `err`.
  - Simultaneous `clr` and capture: the capture wins for its digit and its error bit; all other state clears.
- **Reset mid-count:** all state returns to reset values; no partial capture survives.

## Timing
- Let e0 be the first edge at which new, then-constant inputs are present.
- Capture registers at edge e0+`STABLE_CYC`; `hex`, `dig_vld` and `upd` are visible after that edge.
- `upd` is high for exactly one cycle.
- A change at any edge before e0+`STABLE_CYC` restarts the count. A glitch shorter than `STABLE_CYC` cycles never captures.
- A pattern held indefinitely captures once. Re-capture needs an input change followed by stability.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- `SEG7_RD_BLANK_EN` defined:
  - Pattern 1111111 (all segments off) is "blank".
  - Capture sets `dig_vld[i]`=0 and `upd`=1, holds `hex[i]`, and leaves `err` unchanged.
- Not defined: 1111111 is an undecodable pattern and sets `err`.

## Structure
- **Package `seg7_pkg`:**
  - `seg_t` (logic [6:0]) and `nib_t` (logic [3:0]).
  - Localparam array `SEG_LUT[16]` holding the patterns above.
  - Function `seg2nib(seg_t, output ok)`, shared with the encoder side.
- **Sub-module `seg7_stab`:** parameterized width `W` and `STABLE_CYC`. Holds the sample register and counter and emits the `cap` pulse plus the sampled vector. The decode and storage logic stays in `seg7_reader`.

## Test plan
- Reset defaults: assert `rst_n`=0 mid-count → all outputs 0. Release with inputs held → no `upd` until `STABLE_CYC` stable cycles.
- Valid capture: `an`=4'b1101, `dis`=7'b0110000 held 10 cycles (`STABLE_CYC`=4) → one `upd` at e0+4, `upd_idx`=1, `hex[7:4]`=3, `dig_vld`=4'b0010.
- Glitch rejection: `dis`=7'b0000000 for 3 cycles, then 7'b1111000 held → no capture of 8; capture of 7 at its own e0+4.
- Error path: `an`=4'b0111, `dis`=7'b1010101 → `err`=1, `dig_vld[3]`=0, `upd_idx`=3. Then `clr` in the same cycle as a valid capture on digit 0 → `err`=0 and `dig_vld`=4'b0001.
- Invalid select: `an`=4'b1100 or 4'b1111 held 10 cycles → no `upd`, `err`=0.
- Full scan: rotate digits 0..3 with patterns for A, b, C, d, each held 6 cycles → `hex`=16'hDCBA, `dig_vld`=4'hF. Run 1111111 under both macro settings and check the `err` difference.
